la_ddr_rd_stream: RTL and testbench
===================================

// Module: la_ddr_rd_stream
// PURPOSE
//  Reads back a captured logic-analyser sample region from DDR3 over the AXI read channel (AR + R).
//  Issues incrementing bursts, buffers returned 64-bit beats in an internal FIFO and serialises them
//  LSB-byte-first onto a byte stream (valid/ready) feeding the UART transmitter. Read-side counterpart
//  of the sample writer in my_logic_analysis_top; sits between the DDR3 IP AXI port and the UART TX.
// PARAMETERS
//  CTRL_ADDR_WIDTH  28  AXI address width
//  DATA_WIDTH       64  AXI rdata width (must be multiple of 8)
//  BURST_LEN        16  max beats per burst (axi_arlen = beats-1, 4 bits)
//  ADDR_PER_BEAT    4   address increment per beat (16-bit DQ units per 64-bit beat)
//  FIFO_DEPTH       64  beat FIFO depth, power of 2, >= 2*BURST_LEN
//  LEN_WIDTH        16  width of rd_len (beats)
// PORTS
//  clk           in   1              system clock (AXI clk_ip domain)
//  rst           in   1              synchronous, active-high reset
//  rd_start      in   1              1-cycle pulse: begin readback; ignored while rd_busy
//  rd_base_addr  in   CTRL_ADDR_WIDTH  first beat address, sampled on rd_start
//  rd_len        in   LEN_WIDTH      total beats to read, sampled on rd_start
//  rd_busy       out  1              high from cycle after accepted rd_start until rd_done
//  rd_done       out  1              1-cycle pulse: all beats read and all bytes drained
//  rd_ovf        out  1              sticky: rvalid seen with FIFO full (cleared by rd_start/rst)
//  axi_araddr    out  CTRL_ADDR_WIDTH  burst start address
//  axi_arlen     out  4              beats-1 of current burst
//  axi_arvalid   out  1              AR request; held until axi_arready
//  axi_arready   in   1              AR accept
//  axi_rdata     in   DATA_WIDTH     read data beat
//  axi_rvalid    in   1              read data valid (no rready: slave cannot be stalled)
//  axi_rlast     in   1              last beat of burst
//  dout          out  8              output byte
//  dout_valid    out  1              dout valid
//  dout_ready    in   1              consumer accepts byte when valid&ready
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state S_RD_IDLE. rst mid-operation aborts everything; no rd_done.
//  FSM: S_RD_IDLE -rd_start-> (rd_len==0 ? S_RD_DONE : S_RA_START).
//   S_RA_START: only when FIFO free slots >= beats of this burst (incl. outstanding), drive arvalid;
//     hold araddr/arlen stable until arready; on handshake -> S_RD_WAIT.
//   S_RD_WAIT: wait for beats; each rvalid beat pushed to FIFO; on rvalid&rlast -> S_RD_PROC.
//   S_RD_PROC: remaining beats>0 ? S_RA_START : wait FIFO empty and serialiser idle -> S_RD_DONE.
//   S_RD_DONE: rd_done=1 for one cycle, rd_busy drops same cycle, -> S_RD_IDLE.
//  Burst size = min(remaining, BURST_LEN); arlen = size-1. Next address += size*ADDR_PER_BEAT,
//   modulo 2^CTRL_ADDR_WIDTH (wraps silently).
//  Exactly one burst outstanding at a time. Beat count taken from internal counter; rlast earlier
//   or later than expected: counter wins, rlast only ends WAIT when count matches.
//  arvalid asserted no earlier than 1 cycle after rd_start accepted.
//  Serialiser: pops one FIFO word, emits DATA_WIDTH/8 bytes, byte0 = rdata[7:0] first. dout/dout_valid
//   registered; stay stable while valid&!ready. Back-to-back bytes allowed (1 byte/cycle when ready).
//   Next word loaded without bubble if FIFO non-empty.
//  FIFO full & rvalid: beat dropped, rd_ovf set (cannot happen given credit rule; checked in sim).
//  rd_start while busy: ignored, no state change. rd_start same cycle as rd_done: ignored.
// TESTING
//  1 rd_base_addr=0x100, rd_len=16, dout_ready=1 -> one AR (addr 0x100, arlen 15); 128 bytes in order; rd_done once.
//  2 rd_len=37 -> ARs addr 0/64/128, arlen 15/15/4; 296 bytes; byte0 of beat = rdata[7:0].
//  3 rd_len=64, dout_ready held 0 -> arvalid stalls after FIFO credit exhausted (<=64 beats outstanding);
//    release ready -> all 512 bytes, rd_ovf=0.
//  4 rd_base_addr=0xFFFFFFC, rd_len=32 -> second AR addr 0x000003C (wrap); data intact.
//  5 rd_len=0 -> no arvalid, rd_done 2 cycles after rd_start; rd_start during busy -> ignored.
//  6 rst asserted in S_RD_WAIT mid-burst -> next cycle all outputs 0, no rd_done; fresh rd_start works.

Source files
------------

// File: rtl/la_ddr_rd_stream.sv
`timescale 1ns/1ps
// Reads a captured sample region back from DDR3 over AXI AR/R, buffers the beats and
// streams them out LSB-byte-first on a valid/ready byte interface toward the UART TX.
module la_ddr_rd_stream #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_LEN       = 16,
    parameter int ADDR_PER_BEAT   = 4,
    parameter int FIFO_DEPTH      = 64,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_start,
    input  logic [CTRL_ADDR_WIDTH-1:0] rd_base_addr,
    input  logic [LEN_WIDTH-1:0]       rd_len,
    output logic                       rd_busy,
    output logic                       rd_done,
    output logic                       rd_ovf,
    output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
    output logic [3:0]                 axi_arlen,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [DATA_WIDTH-1:0]      axi_rdata,
    input  logic                       axi_rvalid,
    input  logic                       axi_rlast,
    output logic [7:0]                 dout,
    output logic                       dout_valid,
    input  logic                       dout_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int BW    = $clog2(BYTES + 1);

    typedef enum logic [2:0] {
        S_RD_IDLE,
        S_RA_START,
        S_RD_WAIT,
        S_RD_PROC,
        S_RD_DONE
    } state_t;

    state_t                       state;
    logic [CTRL_ADDR_WIDTH-1:0]   next_addr;
    logic [LEN_WIDTH-1:0]         remaining;
    logic [3:0]                   beat_cnt;
    logic [LEN_WIDTH-1:0]         burst_size;
    logic                         credit_ok;

    logic [DATA_WIDTH-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PW:0]                  wr_ptr;
    logic [PW:0]                  rd_ptr;
    logic [PW:0]                  fifo_cnt;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         push;
    logic [DATA_WIDTH-1:0]        head;

    logic [DATA_WIDTH-1:0]        shift_p0;
    logic [BW-1:0]                left_p0;
    logic                         ser_take;
    logic                         ser_idle;

    // The burst end is defined by the internal beat counter; rlast is informational only.
    logic                         unused_rlast;
    assign unused_rlast = axi_rlast;

    function automatic logic [LEN_WIDTH-1:0] burst_beats(input logic [LEN_WIDTH-1:0] left);
        if (int'(left) > BURST_LEN)
            return LEN_WIDTH'(BURST_LEN);
        return left;
    endfunction

    assign burst_size = burst_beats(remaining);
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    // Only one burst is ever in flight, so free slots must cover the whole next burst.
    assign credit_ok  = (FIFO_DEPTH - int'(fifo_cnt)) >= int'(burst_size);
    assign push       = (state == S_RD_WAIT) && axi_rvalid && !fifo_full;
    assign head       = fifo_mem[rd_ptr[PW-1:0]];
    assign ser_take   = !dout_valid || dout_ready;
    assign ser_idle   = !dout_valid && (left_p0 == '0);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PW-1:0]] <= axi_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RD_IDLE;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            rd_ovf      <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            wr_ptr      <= '0;
        end else begin
            rd_done <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case (state)
                S_RD_IDLE: begin
                    if (rd_start && !rd_done) begin
                        rd_busy   <= 1'b1;
                        rd_ovf    <= 1'b0;
                        next_addr <= rd_base_addr;
                        remaining <= rd_len;
                        state     <= (rd_len == '0) ? S_RD_DONE : S_RA_START;
                    end
                end
                S_RA_START: begin
                    if (axi_arvalid) begin
                        if (axi_arready) begin
                            axi_arvalid <= 1'b0;
                            next_addr   <= next_addr + CTRL_ADDR_WIDTH'(burst_size)
                                                     * CTRL_ADDR_WIDTH'(ADDR_PER_BEAT);
                            remaining   <= remaining - burst_size;
                            beat_cnt    <= '0;
                            state       <= S_RD_WAIT;
                        end
                    end else if (credit_ok) begin
                        axi_arvalid <= 1'b1;
                        axi_araddr  <= next_addr;
                        axi_arlen   <= 4'(burst_size - LEN_WIDTH'(1));
                    end
                end
                S_RD_WAIT: begin
                    if (axi_rvalid) begin
                        if (fifo_full)
                            rd_ovf <= 1'b1;
                        if (beat_cnt == axi_arlen)
                            state <= S_RD_PROC;
                        else
                            beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                S_RD_PROC: begin
                    if (remaining != '0)
                        state <= S_RA_START;
                    else if (fifo_empty && ser_idle)
                        state <= S_RD_DONE;
                end
                S_RD_DONE: begin
                    rd_done <= 1'b1;
                    rd_busy <= 1'b0;
                    state   <= S_RD_IDLE;
                end
                default: state <= S_RD_IDLE;
            endcase
        end
    end

    // Serialiser stage: a freed output slot takes the next byte of the held word, or the
    // FIFO head when the word is exhausted, so words follow each other without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            left_p0    <= '0;
            rd_ptr     <= '0;
        end else if (ser_take) begin
            if (left_p0 != '0) begin
                dout       <= shift_p0[7:0];
                shift_p0   <= shift_p0 >> 8;
                left_p0    <= left_p0 - 1'b1;
                dout_valid <= 1'b1;
            end else if (!fifo_empty) begin
                dout       <= head[7:0];
                shift_p0   <= head >> 8;
                left_p0    <= BW'(BYTES - 1);
                rd_ptr     <= rd_ptr + 1'b1;
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_la_ddr_rd_stream.sv
`timescale 1ns/1ps
// Bench for la_ddr_rd_stream: AXI read slave model, byte consumer and an address/byte reference.
module tb_la_ddr_rd_stream;

    localparam int M_ALWAYS = 0;
    localparam int M_HOLD   = 1;
    localparam int M_RAND   = 2;

    logic        clk;
    logic        rst;
    logic        rd_start;
    logic [27:0] rd_base_addr;
    logic [15:0] rd_len;
    logic        rd_busy, rd_done, rd_ovf;
    logic [27:0] axi_araddr;
    logic [3:0]  axi_arlen;
    logic        axi_arvalid, axi_arready;
    logic [63:0] axi_rdata;
    logic        axi_rvalid, axi_rlast;
    logic [7:0]  dout;
    logic        dout_valid, dout_ready;

    la_ddr_rd_stream dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .rd_base_addr(rd_base_addr),
        .rd_len(rd_len), .rd_busy(rd_busy), .rd_done(rd_done), .rd_ovf(rd_ovf),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
        .axi_rlast(axi_rlast), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic last; } beat_t;
    typedef struct { logic [27:0] addr; logic [3:0] len; } ar_t;
    typedef struct {
        logic [27:0] base; logic [15:0] len; int mode; int stall_ars;
        int exp_ars; logic [27:0] exp_last_addr; int exp_bytes;
    } vec_t;

    beat_t       beat_q[$];
    ar_t         exp_ar_q[$];
    logic [7:0]  exp_byte_q[$];
    int          n_cmp = 0, n_err = 0;
    int          ar_seen = 0, byte_seen = 0, done_cnt = 0, r_sent = 0;
    logic [27:0] last_araddr = '0;
    logic [31:0] salt = 32'h1234_5678;
    int          ready_mode = M_ALWAYS;
    bit          slave_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [27:0] a);
        logic [31:0] x;
        x = {4'h0, a};
        return {x ^ 32'hC0DE_5A17 ^ salt, (x * 32'h9E37_79B1) ^ salt};
    endfunction

    // Reference: burst plan and byte stream derived directly from base/length.
    task automatic model_load(input logic [27:0] base, input logic [15:0] len);
        int          rem, sz;
        logic [27:0] a;
        logic [63:0] d;
        ar_t         r;
        rem = int'(len);
        a = base;
        while (rem > 0) begin
            sz = (rem > 16) ? 16 : rem;
            r.addr = a;
            r.len = 4'(sz - 1);
            exp_ar_q.push_back(r);
            a = a + 28'(sz * 4);
            rem -= sz;
        end
        for (int i = 0; i < int'(len); i++) begin
            d = beat_data(base + 28'(i * 4));
            for (int b = 0; b < 8; b++) exp_byte_q.push_back(d[8*b +: 8]);
        end
    endtask

    // AXI read slave: random arready and rvalid gaps, data is a function of the beat address.
    initial begin
        beat_t b;
        ar_t   e;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
            end else begin
                if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    b = beat_q.pop_front();
                    axi_rvalid = 1'b1; axi_rdata = b.data; axi_rlast = b.last;
                    r_sent++;
                end else begin
                    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = {2{$urandom}};
                end
                if (axi_arvalid && beat_q.size() == 0 && $urandom_range(0, 9) < 7) begin
                    axi_arready = 1'b1;
                    ar_seen++;
                    last_araddr = axi_araddr;
                    check("ar_expected", exp_ar_q.size() > 0, 1);
                    if (exp_ar_q.size() > 0) begin
                        e = exp_ar_q.pop_front();
                        check("araddr", axi_araddr, e.addr);
                        check("arlen", axi_arlen, e.len);
                    end
                    for (int k = 0; k <= int'(axi_arlen); k++) begin
                        b.data = beat_data(axi_araddr + 28'(k * 4));
                        b.last = (k == int'(axi_arlen));
                        beat_q.push_back(b);
                    end
                end else begin
                    axi_arready = 1'b0;
                end
            end
        end
    end

    // Byte consumer: checks order and that a stalled byte stays put.
    initial begin
        logic       hold_prev, r;
        logic [7:0] byte_prev;
        hold_prev = 1'b0; byte_prev = '0; dout_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_prev && !rst) begin
                check("hold_valid", dout_valid, 1);
                check("hold_data", dout, byte_prev);
            end
            case (ready_mode)
                M_ALWAYS: r = 1'b1;
                M_HOLD:   r = 1'b0;
                default:  r = ($urandom_range(0, 3) != 0);
            endcase
            dout_ready = r;
            hold_prev = dout_valid && !r;
            byte_prev = dout;
            if (dout_valid && r && !rst) begin
                byte_seen++;
                check("byte_expected", exp_byte_q.size() > 0, 1);
                if (exp_byte_q.size() > 0) check("byte", dout, exp_byte_q.pop_front());
            end
        end
    end

    always @(negedge clk) if (rd_done) done_cnt++;

    task automatic wait_done(input int d0, input int budget);
        int t;
        t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", t < budget, 1);
    endtask

    task automatic run_read(input logic [27:0] base, input logic [15:0] len, input int mode,
                            input int stall_ars, input bit poke,
                            output int ars, output int bytes, output logic [27:0] last_a);
        int a0, b0, d0;
        salt = $urandom;
        model_load(base, len);
        ready_mode = mode;
        a0 = ar_seen; b0 = byte_seen; d0 = done_cnt;
        @(negedge clk);
        rd_base_addr = base; rd_len = len; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("busy_after_start", rd_busy, 1);
        if (poke) begin
            repeat (5) @(negedge clk);
            rd_base_addr = 28'h0000555; rd_len = 16'd3; rd_start = 1'b1;
            @(negedge clk);
            rd_start = 1'b0;
            check("busy_through_poke", rd_busy, 1);
        end
        if (mode == M_HOLD) begin
            repeat (300) @(negedge clk);
            check("hold_no_done", done_cnt - d0, 0);
            check("hold_no_ovf", rd_ovf, 0);
            if (stall_ars >= 0) begin
                check("hold_ars_issued", ar_seen - a0, stall_ars);
                check("hold_arvalid_low", axi_arvalid, 0);
            end
            ready_mode = M_ALWAYS;
        end
        wait_done(d0, 5000);
        repeat (3) @(negedge clk);
        check("bytes_left", exp_byte_q.size(), 0);
        check("ars_left", exp_ar_q.size(), 0);
        check("ovf_end", rd_ovf, 0);
        check("busy_end", rd_busy, 0);
        check("done_once", done_cnt - d0, 1);
        ars = ar_seen - a0; bytes = byte_seen - b0; last_a = last_araddr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, rd_busy, 0);
        check({tag, "_done"}, rd_done, 0);
        check({tag, "_ovf"}, rd_ovf, 0);
        check({tag, "_arvalid"}, axi_arvalid, 0);
        check({tag, "_araddr"}, axi_araddr, 0);
        check({tag, "_arlen"}, axi_arlen, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
    endtask

    initial begin
        vec_t        vecs[6];
        int          ars, bytes, d0, a0, s0, t;
        logic [27:0] la;
        vecs[0] = '{28'h0000100, 16'd16, M_ALWAYS, -1, 1, 28'h0000100, 128};
        vecs[1] = '{28'h0000000, 16'd37, M_ALWAYS, -1, 3, 28'h0000080, 296};
        vecs[2] = '{28'h0002000, 16'd64, M_HOLD,    4, 4, 28'h00020C0, 512};
        vecs[3] = '{28'hFFFFFFC, 16'd32, M_RAND,   -1, 2, 28'h000003C, 256};
        vecs[4] = '{28'h0ABCDE0, 16'd50, M_RAND,   -1, 4, 28'h0ABCEA0, 400};
        vecs[5] = '{28'h0001230, 16'd1,  M_ALWAYS, -1, 1, 28'h0001230, 8};

        rst = 1'b1; rd_start = 1'b0; rd_base_addr = '0; rd_len = '0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_read(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].stall_ars, 1'b0, ars, bytes, la);
            check($sformatf("vec%0d_ars", i), ars, vecs[i].exp_ars);
            check($sformatf("vec%0d_last_araddr", i), la, vecs[i].exp_last_addr);
            check($sformatf("vec%0d_bytes", i), bytes, vecs[i].exp_bytes);
        end

        // Zero-length read, then a start coinciding with rd_done.
        d0 = done_cnt; a0 = ar_seen;
        @(negedge clk);
        rd_base_addr = 28'h0000777; rd_len = 16'd0; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("len0_busy_c1", rd_busy, 1);
        check("len0_done_c1", rd_done, 0);
        @(negedge clk);
        check("len0_done_c2", rd_done, 1);
        check("len0_busy_c2", rd_busy, 0);
        rd_base_addr = 28'h0000888; rd_len = 16'd5; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("start_on_done_ignored", rd_busy, 0);
        repeat (20) @(negedge clk);
        check("len0_no_ar", ar_seen - a0, 0);
        check("len0_one_done", done_cnt - d0, 1);

        // Credit stall: four bursts fit, the fifth waits for the consumer.
        run_read(28'h0040000, 16'd100, M_HOLD, 4, 1'b0, ars, bytes, la);
        check("stall_bytes", bytes, 800);

        // rd_start while busy must not disturb the running read.
        run_read(28'h0000300, 16'd20, M_ALWAYS, -1, 1'b1, ars, bytes, la);
        check("poke_bytes", bytes, 160);

        // Reset in the middle of a burst.
        salt = $urandom;
        model_load(28'h0005000, 16'd40);
        ready_mode = M_ALWAYS;
        s0 = r_sent;
        @(negedge clk);
        rd_base_addr = 28'h0005000; rd_len = 16'd40; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        t = 0;
        while (!((r_sent - s0) >= 5 && beat_q.size() > 0) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("rst_reached_mid_burst", t < 500, 1);
        rst = 1'b1; slave_en = 1'b0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
        beat_q.delete(); exp_ar_q.delete(); exp_byte_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b0; slave_en = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", rd_busy, 0);
        run_read(28'h0006000, 16'd18, M_ALWAYS, -1, 1'b0, ars, bytes, la);
        check("after_rst_ars", ars, 2);
        check("after_rst_bytes", bytes, 144);

        // Randomised reads against the reference model.
        for (int n = 0; n < 8; n++) begin
            logic [27:0] rb;
            logic [15:0] rl;
            rb = 28'($urandom);
            rl = 16'($urandom_range(1, 80));
            run_read(rb, rl, ($urandom_range(0, 1) == 0) ? M_ALWAYS : M_RAND, -1, 1'b0, ars, bytes, la);
            check($sformatf("rand%0d_bytes", n), bytes, 8 * int'(rl));
            check($sformatf("rand%0d_ars", n), ars, (int'(rl) + 15) / 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
